// File: rtl/free_list_mp_pkg.sv
`default_nettype none
// ==========================================================================
// free_list_mp_pkg : shared sizes and tag type for the rename free list
// Rev 1.0
// ==========================================================================
package free_list_mp_pkg;
  localparam int PREGS      = 64;
  localparam int AREGS      = 32;
  localparam int FL_ALLOC_W = 2;
  localparam int FL_FREE_W  = 2;
  localparam int PTAG_BITS  = $clog2(PREGS);

  typedef logic [PTAG_BITS-1:0] ptag_t;
endpackage
`default_nettype wire

// File: rtl/free_list_mp_if.sv
`default_nettype none
// ==========================================================================
// free_list_mp_if : alloc/free/checkpoint bundle between rename and free list
// Rev 1.0 -- checkpoint signals present only with FREELIST_CKPT_EN
// ==========================================================================
interface free_list_mp_if
  import free_list_mp_pkg::*;
#(
  parameter int ALLOC_W = FL_ALLOC_W,
  parameter int FREE_W  = FL_FREE_W,
  parameter int PTAG_W  = PTAG_BITS
);
  logic [ALLOC_W-1:0]        alloc_req;
  logic                      alloc_gnt;
  logic [ALLOC_W*PTAG_W-1:0] alloc_phys;
  logic [FREE_W-1:0]         free_en;
  logic [FREE_W*PTAG_W-1:0]  free_phys;
  logic [PTAG_W:0]           free_count;
  logic                      err_dbl_free;
`ifdef FREELIST_CKPT_EN
  logic                      ckpt_take;
  logic                      ckpt_restore;

  modport master (
    output alloc_req, free_en, free_phys, ckpt_take, ckpt_restore,
    input  alloc_gnt, alloc_phys, free_count, err_dbl_free
  );
  modport slave (
    input  alloc_req, free_en, free_phys, ckpt_take, ckpt_restore,
    output alloc_gnt, alloc_phys, free_count, err_dbl_free
  );
`else
  modport master (
    output alloc_req, free_en, free_phys,
    input  alloc_gnt, alloc_phys, free_count, err_dbl_free
  );
  modport slave (
    input  alloc_req, free_en, free_phys,
    output alloc_gnt, alloc_phys, free_count, err_dbl_free
  );
`endif
endinterface
`default_nettype wire

// File: rtl/free_list_mp_picker.sv
`default_nettype none
// ==========================================================================
// free_list_mp_picker : finds the K lowest set bits of a mask (tag + one-hot)
// Rev 1.0
// ==========================================================================
module free_list_mp_picker #(
  parameter int N  = 64,
  parameter int K  = 2,
  parameter int TW = 6
) (
  input  logic [N-1:0]          mask_i,
  output logic [K-1:0][TW-1:0]  tag_o,
  output logic [K-1:0][N-1:0]   onehot_o
);
  always_comb begin : pick
    logic [N-1:0] rem;
    logic [N-1:0] oh;
    rem      = mask_i;
    oh       = '0;
    tag_o    = '0;
    onehot_o = '0;
    for (int k = 0; k < K; k++) begin
      // two's-complement trick isolates the lowest remaining set bit
      oh          = rem & (~rem + N'(1));
      onehot_o[k] = oh;
      for (int b = 0; b < N; b++) begin
        if (oh[b]) tag_o[k] = TW'(b);
      end
      rem = rem & ~oh;
    end
  end
endmodule
`default_nettype wire

// File: rtl/free_list_mp.sv
`default_nettype none
// ==========================================================================
// free_list_mp : multi-port bitmask physical-register free list
// Rev 1.0 -- optional single branch checkpoint under FREELIST_CKPT_EN
// ==========================================================================
module free_list_mp
  import free_list_mp_pkg::*;
#(
  parameter int PHYS_REGS = PREGS,
  parameter int ARCH_REGS = AREGS,
  parameter int ALLOC_W   = FL_ALLOC_W,
  parameter int FREE_W    = FL_FREE_W,
  parameter int PTAG_W    = $clog2(PHYS_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  free_list_mp_if.slave fl
);
  localparam logic [PHYS_REGS-1:0] RESET_MASK = {PHYS_REGS{1'b1}} << ARCH_REGS;
  localparam logic [PTAG_W:0]      RESET_CNT  = (PTAG_W+1)'(PHYS_REGS - ARCH_REGS);

  logic [PHYS_REGS-1:0] mask_q, mask_d, mask_next;
  logic [PTAG_W:0]      count_q, count_d;
  logic                 err_q, err_d;

  logic [ALLOC_W-1:0][PTAG_W-1:0]    pick_tag;
  logic [ALLOC_W-1:0][PHYS_REGS-1:0] pick_oh;
  logic [ALLOC_W-1:0][PTAG_W-1:0]    phys;
  logic [PHYS_REGS-1:0]              grant_vec;
  logic [PHYS_REGS-1:0]              freed_vec;
  logic [PTAG_W:0]                   req_cnt, alloc_cnt, new_cnt;
  logic                              gnt, dbl, restore;

`ifdef FREELIST_CKPT_EN
  logic [PHYS_REGS-1:0] ckpt_q, ckpt_d;
  assign restore = fl.ckpt_restore;

  function automatic logic [PTAG_W:0] popcnt(input logic [PHYS_REGS-1:0] v);
    popcnt = '0;
    for (int b = 0; b < PHYS_REGS; b++) popcnt = popcnt + (PTAG_W+1)'(v[b]);
  endfunction
`else
  assign restore = 1'b0;
`endif

  free_list_mp_picker #(
    .N  (PHYS_REGS),
    .K  (ALLOC_W),
    .TW (PTAG_W)
  ) u_picker (
    .mask_i   (mask_q),
    .tag_o    (pick_tag),
    .onehot_o (pick_oh)
  );

  // Requested ports are ranked in port order; an idle port just shows pick[i].
  always_comb begin : grant
    int rank;
    req_cnt = '0;
    for (int i = 0; i < ALLOC_W; i++) req_cnt = req_cnt + (PTAG_W+1)'(fl.alloc_req[i]);
    gnt       = (req_cnt <= count_q) && !restore;
    alloc_cnt = gnt ? req_cnt : '0;
    grant_vec = '0;
    rank      = 0;
    for (int i = 0; i < ALLOC_W; i++) begin
      phys[i] = pick_tag[i];
      if (fl.alloc_req[i]) begin
        for (int k = 0; k < ALLOC_W; k++) begin
          if (k == rank) begin
            phys[i] = pick_tag[k];
            if (gnt) grant_vec = grant_vec | pick_oh[k];
          end
        end
        rank = rank + 1;
      end
    end
  end

  // A free of an already-free tag, or a repeat within the cycle, only flags.
  always_comb begin : frees
    logic [PTAG_W-1:0] tag;
    tag       = '0;
    freed_vec = '0;
    dbl       = 1'b0;
    new_cnt   = '0;
    for (int j = 0; j < FREE_W; j++) begin
      if (fl.free_en[j]) begin
        tag = fl.free_phys[j*PTAG_W +: PTAG_W];
        if (mask_q[tag] || freed_vec[tag]) dbl = 1'b1;
        else                               new_cnt = new_cnt + 1'b1;
        freed_vec[tag] = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    mask_next = (mask_q & ~grant_vec) | freed_vec;
    mask_d    = mask_next;
    count_d   = count_q - alloc_cnt + new_cnt;
    err_d     = err_q | dbl;
`ifdef FREELIST_CKPT_EN
    ckpt_d = ckpt_q | freed_vec;
    if (restore) begin
      mask_d  = ckpt_q | freed_vec;
      count_d = popcnt(ckpt_q | freed_vec);
    end else if (fl.ckpt_take) begin
      ckpt_d = mask_next;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= RESET_MASK;
      count_q <= RESET_CNT;
      err_q   <= 1'b0;
`ifdef FREELIST_CKPT_EN
      ckpt_q  <= RESET_MASK;
`endif
    end else begin
      mask_q  <= mask_d;
      count_q <= count_d;
      err_q   <= err_d;
`ifdef FREELIST_CKPT_EN
      ckpt_q  <= ckpt_d;
`endif
    end
  end

  assign fl.alloc_gnt    = gnt;
  assign fl.alloc_phys   = phys;
  assign fl.free_count   = count_q;
  assign fl.err_dbl_free = err_q;
endmodule
`default_nettype wire
